// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the RV32I core.
// Each instruction steps through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The block enables the decoder, runs the imem/dmem request handshakes and
// drives the PC, IR and register-file write strobes. Illegal decodes and
// bus timeouts drop it into a sticky TRAP that only rst_n leaves.
//
// Optional build macro: CPU_PERF_CNT_EN enables the cycle and
// retired-instruction counters. When it is undefined, both ports read 0.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   halt                     hold in FETCH before a request is raised
//   imem_req/imem_ack        instruction fetch handshake; ir_we on ack
//   dec_en                   decoder enable (DECODE, EXEC, MEM)
//   is_* / invalid_instruction  decoder class flags, sampled in DECODE
//   rd                       destination index (rf_we suppressed for x0)
//   branch_taken             branch compare result, used in EXEC
//   alu_src_imm              ALU operand B select
//   dmem_req/dmem_we/dmem_ack  data memory handshake
//   rf_we, wb_sel            register write strobe, writeback source select
//   pc_we, pc_sel            PC update strobe, 0 = PC+PC_STEP, 1 = target
//   trap, trap_cause         sticky trap flag and cause code
//   state                    current state encoding for debug
//   cycle_cnt, instret_cnt   performance counters
module cpu_ctrl_fsm #(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic        dec_en,
  input  logic        is_alu_r,
  input  logic        is_alu_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        invalid_instruction,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        alu_src_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Last count value at which a missing ack still gets one more cycle;
  // a request without ack while the count equals this value times out.
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  // PC_STEP only documents the datapath adder that pc_sel=0 selects.
  if (PC_STEP == 0) begin : g_pc_step_zero
  end

  state_t      st;
  logic [15:0] to_cnt;
  logic        fetch_busy;  // fetch request already raised; halt no longer applies
  logic [1:0]  cause_q;

  // Decoded class captured in DECODE so later states do not depend on
  // the decoder flags staying stable.
  logic        c_alu;
  logic        c_load;
  logic        c_store;
  logic        c_branch;
  logic        c_imm;

  logic        fetch_req;
  logic        class_ok;

  assign fetch_req = (st == S_FETCH) && (fetch_busy || !halt);
  assign class_ok  = !invalid_instruction &&
                     $onehot({is_alu_r, is_alu_i, is_load, is_store, is_branch});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_FETCH;
      to_cnt     <= '0;
      fetch_busy <= 1'b0;
      cause_q    <= 2'b00;
      c_alu      <= 1'b0;
      c_load     <= 1'b0;
      c_store    <= 1'b0;
      c_branch   <= 1'b0;
      c_imm      <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (fetch_req) begin
            if (imem_ack) begin
              st         <= S_DECODE;
              to_cnt     <= '0;
              fetch_busy <= 1'b0;
            end else if (to_cnt == TO_LAST) begin
              st         <= S_TRAP;
              cause_q    <= 2'b10;
              fetch_busy <= 1'b0;
            end else begin
              to_cnt     <= to_cnt + 16'd1;
              fetch_busy <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (class_ok) begin
            st       <= S_EXEC;
            c_alu    <= is_alu_r | is_alu_i;
            c_load   <= is_load;
            c_store  <= is_store;
            c_branch <= is_branch;
            c_imm    <= is_alu_i | is_load | is_store;
          end else begin
            st      <= S_TRAP;
            cause_q <= 2'b01;
          end
        end
        S_EXEC: begin
          to_cnt <= '0;
          if (c_alu)         st <= S_WB;
          else if (c_branch) st <= S_FETCH;
          else               st <= S_MEM;
        end
        S_MEM: begin
          if (dmem_ack) begin
            to_cnt <= '0;
            st     <= c_store ? S_FETCH : S_WB;
          end else if (to_cnt == TO_LAST) begin
            st      <= S_TRAP;
            cause_q <= 2'b11;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_WB: begin
          to_cnt <= '0;
          st     <= S_FETCH;
        end
        S_TRAP:  st <= S_TRAP;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Strobes decode from registered state plus inputs only. Reset parks the
  // state in FETCH, so the fetch request is the one output that also needs
  // rst_n to stay low while reset is held.
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dec_en      = 1'b0;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    case (st)
      S_FETCH: begin
        imem_req = rst_n && fetch_req;
        ir_we    = rst_n && fetch_req && imem_ack;
      end
      S_DECODE: dec_en = 1'b1;
      S_EXEC: begin
        dec_en      = 1'b1;
        alu_src_imm = c_imm;
        pc_we       = c_branch;
        pc_sel      = c_branch && branch_taken;
      end
      S_MEM: begin
        dec_en      = 1'b1;
        alu_src_imm = 1'b1;
        dmem_req    = 1'b1;
        dmem_we     = c_store;
        pc_we       = c_store && dmem_ack;
      end
      S_WB: begin
        rf_we  = (rd != 5'd0);
        wb_sel = c_load;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = (st == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = st;

`ifdef CPU_PERF_CNT_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (st != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (pc_we)        ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Testbench for cpu_ctrl_fsm: cycle tables, hand-written trap/timeout/reset
// sequences, and randomized instructions against a per-instruction model.
module tb_cpu_ctrl_fsm;

  localparam int unsigned TO = 8;
  localparam logic [4:0] ADD  = 5'b10000;
  localparam logic [4:0] ADDI = 5'b01000;
  localparam logic [4:0] LW   = 5'b00100;
  localparam logic [4:0] SW   = 5'b00010;
  localparam logic [4:0] BR   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, imem_req, imem_ack, ir_we, dec_en;
  logic        is_alu_r, is_alu_i, is_load, is_store, is_branch;
  logic        invalid_instruction, branch_taken, alu_src_imm;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ack, rf_we, wb_sel, pc_we, pc_sel, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.TO_CYCLES(TO), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .imem_req(imem_req),
    .imem_ack(imem_ack), .ir_we(ir_we), .dec_en(dec_en),
    .is_alu_r(is_alu_r), .is_alu_i(is_alu_i), .is_load(is_load),
    .is_store(is_store), .is_branch(is_branch),
    .invalid_instruction(invalid_instruction), .rd(rd),
    .branch_taken(branch_taken), .alu_src_imm(alu_src_imm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // One cycle of inputs plus the expected state and strobes.
  // o = {imem_req,ir_we, dec_en,dmem_req,dmem_we,alu_src_imm, rf_we,wb_sel, pc_we,pc_sel, trap}
  typedef struct {
    logic        h, ia, da;
    logic [4:0]  cls;
    logic        inv;
    logic [4:0]  r;
    logic        tk;
    logic [2:0]  st;
    logic [10:0] o;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic h, input logic ia, input logic da,
                              input logic [4:0] cls, input logic inv,
                              input logic [4:0] r, input logic tk,
                              input logic [2:0] st, input logic [10:0] o);
    vec_t v;
    v.h = h; v.ia = ia; v.da = da; v.cls = cls; v.inv = inv;
    v.r = r; v.tk = tk; v.st = st; v.o = o;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {imem_req, ir_we, dec_en, dmem_req, dmem_we, alu_src_imm,
            rf_we, wb_sel, pc_we, pc_sel, trap};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic ia, input logic da,
                       input logic [4:0] cls, input logic inv,
                       input logic [4:0] r, input logic tk);
    halt = h; imem_ack = ia; dmem_ack = da;
    {is_alu_r, is_alu_i, is_load, is_store, is_branch} = cls;
    invalid_instruction = inv; rd = r; branch_taken = tk;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at posedge+1 with no clock edge seen since release.
  task automatic do_reset();
    drive(0, 0, 0, 5'b0, 0, 5'd0, 0);
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    int unsigned n_pc = 0;
    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].h, tv[i].ia, tv[i].da, tv[i].cls, tv[i].inv, tv[i].r, tv[i].tk);
      #2;
      chk($sformatf("vec%0d state", i), 32'(state), 32'(tv[i].st));
      chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(tv[i].o));
      if (tv[i].o[2]) n_pc++;
      next_cycle();
    end
`ifdef CPU_PERF_CNT_EN
    chk("table cycle_cnt", cycle_cnt, 32'(tv.size()));
    chk("table instret_cnt", instret_cnt, n_pc);
`else
    chk("table cycle_cnt", cycle_cnt, 32'd0);
    chk("table instret_cnt", instret_cnt, 32'd0);
`endif
  endtask

  task automatic run_illegal(input logic [4:0] cls, input logic inv, input string tag);
    do_reset();
    drive(0, 1, 0, cls, inv, 5'd3, 0);
    #2 chk({tag, " ir_we"}, 32'(ir_we), 32'd1);
    next_cycle();
    #2 chk({tag, " decode"}, 32'(state), 32'd1);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, cls, inv, 5'd3, 1);
      #2 chk($sformatf("%s imem_req c%0d", tag, i), 32'(imem_req), 32'd0);
      next_cycle();
    end
    #2;
    chk({tag, " state"}, 32'(state), 32'd5);
    chk({tag, " outs"}, 32'(outs()), 32'h001);
    chk({tag, " cause"}, 32'(trap_cause), 32'd1);
  endtask

  task automatic run_imem_timeout(input logic ack_last);
    string tag = ack_last ? "imem ack@8" : "imem timeout";
    do_reset();
    for (int k = 1; k <= int'(TO); k++) begin
      drive(0, (ack_last && k == int'(TO)), 0, ADDI, 0, 5'd1, 0);
      #2 chk($sformatf("%s req c%0d", tag, k), 32'(imem_req), 32'd1);
      next_cycle();
    end
    #2;
    chk({tag, " state"}, 32'(state), ack_last ? 32'd1 : 32'd5);
    chk({tag, " cause"}, 32'(trap_cause), ack_last ? 32'd0 : 32'd2);
    if (!ack_last) begin
      for (int i = 0; i < 3; i++) next_cycle();
      #2;
      chk({tag, " still trapped"}, 32'(trap), 32'd1);
`ifdef CPU_PERF_CNT_EN
      chk({tag, " cycle_cnt frozen"}, cycle_cnt, TO);
`endif
    end
  endtask

  task automatic run_dmem_timeout();
    do_reset();
    drive(0, 1, 0, LW, 0, 5'd2, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    for (int k = 1; k <= int'(TO); k++) begin
      #2 chk($sformatf("dmem timeout req c%0d", k), 32'(dmem_req), 32'd1);
      next_cycle();
    end
    #2;
    chk("dmem timeout state", 32'(state), 32'd5);
    chk("dmem timeout cause", 32'(trap_cause), 32'd3);
    chk("dmem timeout req drop", 32'(dmem_req), 32'd0);
  endtask

  task automatic run_reset_in_mem();
    do_reset();
    drive(0, 1, 0, SW, 0, 5'd4, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    drive(0, 0, 0, SW, 0, 5'd4, 0);
    #2 chk("mid-mem dmem_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset dmem_req", 32'(dmem_req), 32'd0);
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset outs", 32'(outs()), 32'd0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Per-instruction model: cycle count, strobe tallies and branch select
  // follow from the class and the chosen wait states.
  task automatic run_random(input int unsigned n_instr);
    int unsigned total = 0;
    int unsigned n_done = 0;
    do_reset();
    for (int n = 0; n < int'(n_instr); n++) begin
      int unsigned k, wi, wd, h, cyc;
      int unsigned exp_cyc, exp_dreq, exp_dwe;
      int unsigned c_ireq, c_irw, c_dreq, c_dwe, c_rf, c_wb, c_pc;
      logic [4:0] cls, r;
      logic tk, sel_at, done, hh, is_alu, is_ld, is_st, is_br;
      k  = $urandom_range(0, 4);
      cls = 5'(5'b10000 >> k);
      r  = 5'($urandom_range(0, 31));
      tk = 1'($urandom_range(0, 1));
      wi = $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      h  = $urandom_range(0, 2);
      is_alu = (k <= 1); is_ld = (k == 2); is_st = (k == 3); is_br = (k == 4);
      exp_cyc  = h + wi + 2 + (is_br ? 1 : is_alu ? 2 : is_st ? wd + 2 : wd + 3);
      exp_dreq = (is_ld || is_st) ? wd + 1 : 0;
      exp_dwe  = is_st ? wd + 1 : 0;
      c_ireq = 0; c_irw = 0; c_dreq = 0; c_dwe = 0; c_rf = 0; c_wb = 0; c_pc = 0;
      cyc = 0; done = 1'b0; sel_at = 1'b0;
      while (!done && cyc < 40) begin
        hh = (cyc < h) ? 1'b1 : (cyc == h) ? 1'b0 : 1'($urandom_range(0, 1));
        drive(hh, 0, 0, cls, 0, r, tk);
        #1;
        imem_ack = imem_req && (c_ireq == wi);
        dmem_ack = dmem_req && (c_dreq == wd);
        #1;
        c_ireq += 32'(imem_req); c_irw += 32'(ir_we);
        c_dreq += 32'(dmem_req); c_dwe += 32'(dmem_we);
        c_rf   += 32'(rf_we);    c_wb  += 32'(wb_sel);
        if (pc_we) begin c_pc++; sel_at = pc_sel; done = 1'b1; end
        cyc++;
        next_cycle();
      end
      chk($sformatf("rnd%0d cycles", n), cyc, exp_cyc);
      chk($sformatf("rnd%0d imem_req", n), c_ireq, wi + 1);
      chk($sformatf("rnd%0d ir_we", n), c_irw, 32'd1);
      chk($sformatf("rnd%0d dmem_req", n), c_dreq, exp_dreq);
      chk($sformatf("rnd%0d dmem_we", n), c_dwe, exp_dwe);
      chk($sformatf("rnd%0d rf_we", n), c_rf, ((is_alu || is_ld) && r != 0) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d wb_sel", n), c_wb, is_ld ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d pc_we", n), c_pc, 32'd1);
      chk($sformatf("rnd%0d pc_sel", n), 32'(sel_at), 32'(is_br && tk));
      total += exp_cyc;
      if (done) n_done++;
      else do_reset();
    end
`ifdef CPU_PERF_CNT_EN
    chk("rnd cycle_cnt", cycle_cnt, total);
    chk("rnd instret_cnt", instret_cnt, n_instr);
`else
    chk("rnd cycle_cnt", cycle_cnt, 32'd0);
    chk("rnd instret_cnt", instret_cnt, 32'd0);
`endif
    chk("rnd completed", n_done, n_instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addi x5: FETCH, DECODE, EXEC, WB
    tv.push_back(mk(0,1,0,ADDI,0,5,0, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(0,0,0,ADDI,0,5,0, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,ADDI,0,5,0, 2, 11'b00_1001_00_00_0));
    tv.push_back(mk(0,0,0,ADDI,0,5,0, 4, 11'b00_0000_10_10_0));
    // branch taken / not taken
    tv.push_back(mk(0,1,0,BR,0,0,1, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(0,0,0,BR,0,0,1, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,BR,0,0,1, 2, 11'b00_1000_00_11_0));
    tv.push_back(mk(0,1,0,BR,0,0,0, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(0,0,0,BR,0,0,0, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,BR,0,0,0, 2, 11'b00_1000_00_10_0));
    // store, zero wait: pc_we on ack, never rf_we
    tv.push_back(mk(0,1,0,SW,0,7,0, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(0,0,0,SW,0,7,0, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,SW,0,7,0, 2, 11'b00_1001_00_00_0));
    tv.push_back(mk(0,0,1,SW,0,7,0, 3, 11'b00_1111_00_10_0));
    // load with ack on the 4th MEM cycle
    tv.push_back(mk(0,1,0,LW,0,9,0, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 2, 11'b00_1001_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 3, 11'b00_1101_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 3, 11'b00_1101_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 3, 11'b00_1101_00_00_0));
    tv.push_back(mk(0,0,1,LW,0,9,0, 3, 11'b00_1101_00_00_0));
    tv.push_back(mk(0,0,0,LW,0,9,0, 4, 11'b00_0000_11_10_0));
    // halt before request, halt ignored once raised, add x0
    tv.push_back(mk(1,0,0,ADD,0,0,0, 0, 11'b00_0000_00_00_0));
    tv.push_back(mk(1,0,0,ADD,0,0,0, 0, 11'b00_0000_00_00_0));
    tv.push_back(mk(0,0,0,ADD,0,0,0, 0, 11'b10_0000_00_00_0));
    tv.push_back(mk(1,0,0,ADD,0,0,0, 0, 11'b10_0000_00_00_0));
    tv.push_back(mk(1,1,0,ADD,0,0,0, 0, 11'b11_0000_00_00_0));
    tv.push_back(mk(1,0,0,ADD,0,0,0, 1, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,ADD,0,0,0, 2, 11'b00_1000_00_00_0));
    tv.push_back(mk(0,0,0,ADD,0,0,0, 4, 11'b00_0000_00_10_0));

    // Reset values while rst_n is held low.
    drive(0, 0, 0, 5'b0, 0, 5'd0, 0);
    rst_n = 1'b0;
    #3;
    chk("reset state", 32'(state), 32'd0);
    chk("reset outs", 32'(outs()), 32'd0);
    chk("reset cause", 32'(trap_cause), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    chk("reset instret_cnt", instret_cnt, 32'd0);

    run_table();
    run_illegal(ADDI, 1'b1, "illegal flag");
    run_illegal(5'b00110, 1'b0, "load+store");
    run_illegal(5'b00000, 1'b0, "no class");
    run_imem_timeout(1'b0);
    run_imem_timeout(1'b1);
    run_dmem_timeout();
    run_reset_in_mem();
    run_random(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It owns the enable of the instruction decoder and the imem/dmem request handshakes, and drives the PC, IR and register-file write strobes. Its decode-class inputs come from the decoder's flag outputs; illegal instructions and bus timeouts send it into a sticky trap.

Parameters:
TO_CYCLES, 255, max cycles a memory request may wait for ack before a timeout trap (1..65535)
PC_STEP, 4, PC increment for sequential flow (informational; selected via pc_sel)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
halt  in  1  hold in FETCH without issuing a request
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid; IR captured this cycle
ir_we  out  1  instruction register load strobe
dec_en  out  1  decoder enable
is_alu_r  in  1  decoded class: register ALU op
is_alu_i  in  1  decoded class: immediate ALU op
is_load  in  1  decoded class: load
is_store  in  1  decoded class: store
is_branch  in  1  decoded class: conditional branch
invalid_instruction  in  1  decoder illegal flag
rd  in  5  destination register index
branch_taken  in  1  branch comparison result, valid in EXEC
alu_src_imm  out  1  ALU operand B = immediate
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data memory completion
rf_we  out  1  register file write strobe
wb_sel  out  1  0 = ALU result, 1 = load data
pc_we  out  1  PC update strobe
pc_sel  out  1  0 = PC+PC_STEP, 1 = branch target
trap  out  1  sticky trap indicator
trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
state  out  3  current state encoding, for debug
cycle_cnt  out  32  cycle counter (see Optional Feature)
instret_cnt  out  32  retired-instruction counter (see Optional Feature)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. All outputs are decoded from registered state plus inputs; there are no combinational paths from ack to req.
- Reset (rst_n low, asynchronous): state=FETCH, trap=0, trap_cause=00, timeout counter=0, counters=0. All strobes are 0.
- FETCH:
  - halt=1: imem_req=0, stay in FETCH.
  - Otherwise imem_req=1, held until imem_ack. On ack: ir_we=1 in the same cycle, go to DECODE.
- DECODE: dec_en=1 for exactly 1 cycle.
  - invalid_instruction=1, or zero class bits set, or more than one class bit set: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC: dec_en=1, alu_src_imm=is_alu_i|is_load|is_store.
  - ALU op: go to WB.
  - Branch: pc_we=1, pc_sel=branch_taken, go to FETCH.
  - Load or store: go to MEM.
- MEM: dec_en=1, dmem_req=1, dmem_we=is_store, alu_src_imm=1, all held stable until dmem_ack.
  - On ack for a store: pc_we=1, pc_sel=0, go to FETCH.
  - On ack for a load: go to WB.
- WB: rf_we=(rd!=0), wb_sel=is_load, pc_we=1, pc_sel=0, go to FETCH.
- Latency without wait states: ALU op 4 cycles, branch 3, store 4, load 5.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle req is high without ack.
  - When it reaches TO_CYCLES with no ack, go to TRAP with cause 10 (imem) or 11 (dmem).
  - An ack arriving in the same cycle the count hits TO_CYCLES wins; the access completes normally.
- TRAP: trap=1, all strobes and requests 0. The state is absorbing; only rst_n exits it. trap_cause holds its value.
- halt does not interrupt an in-flight instruction; it is sampled only in FETCH before the request is raised. Once imem_req is high, it stays high until ack or timeout regardless of halt.
- Reset asserted mid-access drops imem_req/dmem_req asynchronously. No write strobe may glitch high.

Optional Feature:
CPU_PERF_CNT_EN
- Defined: cycle_cnt increments every clock while not in TRAP. instret_cnt increments on each pc_we (retirement). Both wrap 0xFFFFFFFF to 0 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- ALU op: addi, rd=5, zero-wait acks -> states 0,1,2,4,0; rf_we=1 and pc_we=1 in cycle 4; instret_cnt=1 (with CPU_PERF_CNT_EN).
- Load with 3-cycle dmem_ack delay -> dmem_req high 4 consecutive cycles, then WB with wb_sel=1; store -> pc_we on the ack cycle, rf_we never asserted.
- Branch: is_branch with branch_taken=1 -> pc_we=1, pc_sel=1 in EXEC; branch_taken=0 -> pc_sel=0.
- invalid_instruction=1, or is_load=is_store=1 in DECODE -> TRAP, trap_cause=01, imem_req stays 0 for the next 20 cycles.
- TO_CYCLES=8, imem_ack never asserted -> TRAP with cause 10 after 8 request cycles; ack on exactly cycle 8 -> normal DECODE.
- ALU op with rd=0 -> rf_we=0 in WB, pc_we=1. rst_n pulsed low during MEM -> dmem_req falls immediately, state=0.
